// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin single-transaction memory arbiter; ports: clk, reset, core_enable/core_addr/core_wr_data in, ready_sig/rd_data out, mem_req/mem_we/mem_addr/mem_wr_data/mem_ack/mem_rd_data memory side, busy, err_illegal, err_timeout
module mem_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int REG_SIZE = 8,
  parameter int ADDR_SIZE = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*CORE_COUNT-1:0]         core_enable,
  input  logic [CORE_COUNT*ADDR_SIZE-1:0] core_addr,
  input  logic [CORE_COUNT*REG_SIZE-1:0]  core_wr_data,
  output logic [CORE_COUNT-1:0]           ready_sig,
  output logic [REG_SIZE-1:0]             rd_data,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  output logic [REG_SIZE-1:0]             mem_wr_data,
  input  logic                            mem_ack,
  input  logic [REG_SIZE-1:0]             mem_rd_data,
  output logic                            busy,
  output logic                            err_illegal,
  output logic                            err_timeout
);
  localparam int GW = $clog2(CORE_COUNT);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] last_grant, grant, pick;
  logic [7:0] cnt;
  logic found, illegal, expire;
  int idx;
  always_comb begin
    found = 1'b0;
    pick = '0;
    illegal = 1'b0;
    idx = 0;
    for (int k = 1; k <= CORE_COUNT; k++) begin
      idx = (int'(last_grant) + k) % CORE_COUNT;
      if (!found && (core_enable[2*idx +: 2] == 2'b01 || core_enable[2*idx +: 2] == 2'b10)) begin
        found = 1'b1;
        pick = GW'(idx);
      end
    end
    for (int i = 0; i < CORE_COUNT; i++)
      illegal = illegal | (core_enable[2*i +: 2] == 2'b11);
  end
  assign expire = cnt == 8'(TIMEOUT - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (found ? WAIT : IDLE) :
                state == WAIT ? ((mem_ack || expire) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GW'(CORE_COUNT - 1);
      grant <= '0;
      cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wr_data <= '0;
      rd_data <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_illegal <= err_illegal | illegal;
      if (state == IDLE && found) begin
        grant <= pick;
        last_grant <= pick;
        mem_addr <= core_addr[pick*ADDR_SIZE +: ADDR_SIZE];
        mem_wr_data <= core_wr_data[pick*REG_SIZE +: REG_SIZE];
        mem_we <= core_enable[2*pick +: 2] == 2'b10;
        cnt <= '0;
      end
      if (state == WAIT) begin
        if (mem_ack) rd_data <= mem_we ? '0 : mem_rd_data;
        else if (expire) begin
          rd_data <= '0;
          err_timeout <= 1'b1;
        end else cnt <= cnt + 8'd1;
      end
    end
  end
  assign mem_req = state == WAIT;
  assign busy = state != IDLE;
  assign ready_sig = state == DONE ? {{(CORE_COUNT-1){1'b0}}, 1'b1} << grant : '0;
endmodule
